// File: rtl/neopix_pkg.sv
// neopix_pkg: shared state encoding, timing defaults and ns/us-to-cycle conversion for the WS2812 serializer.
package neopix_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND, ST_LATCH} state_t;
  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_SYSTEM_CLOCK = 50_000_000;
  localparam int DEF_T0H_NS = 400;
  localparam int DEF_T1H_NS = 800;
  localparam int DEF_BIT_NS = 1250;
  localparam int DEF_RESET_US = 50;
  function automatic int ns_to_cyc(input int sys_clk, input int ns);
    return (sys_clk / 1_000_000) * ns / 1000;
  endfunction
  function automatic int us_to_cyc(input int sys_clk, input int us);
    return (sys_clk / 1_000_000) * us;
  endfunction
endpackage

// File: rtl/neopix_if.sv
// neopix_if: frame control and pixel-RAM read port between the upstream stage and the serializer.
interface neopix_if import neopix_pkg::*; #(
  parameter int NUM_LEDS = DEF_NUM_LEDS
);
  localparam int AW = $clog2(NUM_LEDS);
  logic          start_i;
  logic [AW:0]   led_count_i;
  logic          busy_o;
  logic          data_request_o;
  logic [AW-1:0] address_o;
  logic [7:0]    red_i;
  logic [7:0]    green_i;
  logic [7:0]    blue_i;
  modport slave (
    input  start_i, led_count_i, red_i, green_i, blue_i,
    output busy_o, data_request_o, address_o
  );
  modport master (
    output start_i, led_count_i, red_i, green_i, blue_i,
    input  busy_o, data_request_o, address_o
  );
endinterface

// File: rtl/neopix_bit_timer.sv
// neopix_bit_timer: per-bit cycle counter and registered high/low decision for the WS2812 line.
module neopix_bit_timer #(
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40,
  parameter int BIT_CYC = 62
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic i_start,
  input  logic i_run,
  input  logic i_bit,
  input  logic i_last,
  output logic o_done,
  output logic o_first,
  output logic o_do
);
  localparam int CW = $clog2(BIT_CYC);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;
  logic [CW-1:0] w_th;
  assign w_nxt   = r_cnt + 1'b1;
  assign w_th    = i_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign o_done  = i_run && r_cnt == CW'(BIT_CYC - 1);
  assign o_first = r_cnt == '0;
  // every bit opens high, so the line level is decided one cycle ahead from the next count
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
      o_do  <= 1'b0;
    end else if (i_start) begin
      r_cnt <= '0;
      o_do  <= 1'b1;
    end else if (o_done) begin
      r_cnt <= '0;
      o_do  <= !i_last;
    end else if (i_run) begin
      r_cnt <= w_nxt;
      o_do  <= w_nxt < w_th;
    end else begin
      r_cnt <= '0;
      o_do  <= 1'b0;
    end
  end
endmodule

// File: rtl/neopix_tx.sv
// neopix_tx: fetches GRB words from pixel RAM with one-word prefetch and serializes them onto the WS2812 line.
module neopix_tx import neopix_pkg::*; #(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int SYSTEM_CLOCK = DEF_SYSTEM_CLOCK,
  parameter int T0H_NS       = DEF_T0H_NS,
  parameter int T1H_NS       = DEF_T1H_NS,
  parameter int BIT_NS       = DEF_BIT_NS,
  parameter int RESET_US     = DEF_RESET_US
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  neopix_if.slave  bus,
  output logic     do_o
);
  localparam int AW        = $clog2(NUM_LEDS);
  localparam int CW        = AW + 1;
  localparam int LATCH_CYC = us_to_cyc(SYSTEM_CLOCK, RESET_US);
  localparam int LW        = $clog2(LATCH_CYC);
  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_led;
  logic [4:0]    r_bit;
  logic [23:0]   r_shift;
  logic [23:0]   r_hold;
  logic [LW-1:0] r_lat;
  logic          r_pend;
  logic          r_cap;
  logic          w_done;
  logic          w_first;
  logic          w_more;
  logic          w_last;
  logic          w_start;
  logic [CW-1:0] w_next_led;
  logic [CW-1:0] w_req_count;
  logic [23:0]   w_word;
  assign w_next_led  = r_led + 1'b1;
  assign w_more      = w_next_led < r_count;
  assign w_last      = r_bit == 5'd0 && !w_more;
  assign w_start     = r_state == ST_FETCH && r_cap;
  assign w_word      = {bus.green_i, bus.red_i, bus.blue_i};
  assign w_req_count = bus.led_count_i > CW'(NUM_LEDS) ? CW'(NUM_LEDS) : bus.led_count_i;
  // r_pend marks "address is on the bus", r_cap marks "RAM data is valid this cycle"
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state            <= ST_IDLE;
      r_count            <= '0;
      r_led              <= '0;
      r_bit              <= '0;
      r_shift            <= '0;
      r_hold             <= '0;
      r_lat              <= '0;
      r_pend             <= 1'b0;
      r_cap              <= 1'b0;
      bus.busy_o         <= 1'b0;
      bus.data_request_o <= 1'b0;
      bus.address_o      <= '0;
    end else begin
      bus.data_request_o <= r_pend;
      r_pend             <= 1'b0;
      r_cap              <= bus.data_request_o;
      case (r_state)
        ST_IDLE: if (bus.start_i && bus.led_count_i != '0) begin
          r_state       <= ST_FETCH;
          bus.busy_o    <= 1'b1;
          bus.address_o <= '0;
          r_count       <= w_req_count;
          r_led         <= '0;
          r_pend        <= 1'b1;
        end
        ST_FETCH: if (r_cap) begin
          r_shift <= w_word;
          r_bit   <= 5'd23;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (r_cap) r_hold <= w_word;
          if (w_first && r_bit == 5'd23 && w_more) begin
            bus.address_o <= w_next_led[AW-1:0];
            r_pend        <= 1'b1;
          end
          if (w_done) begin
            if (r_bit != 5'd0) begin
              r_shift <= {r_shift[22:0], 1'b0};
              r_bit   <= r_bit - 1'b1;
            end else if (w_more) begin
              r_shift <= r_hold;
              r_bit   <= 5'd23;
              r_led   <= w_next_led;
            end else begin
              r_state <= ST_LATCH;
              r_lat   <= '0;
            end
          end
        end
        ST_LATCH: if (r_lat == LW'(LATCH_CYC - 1)) begin
          r_state    <= ST_IDLE;
          bus.busy_o <= 1'b0;
        end else begin
          r_lat <= r_lat + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  neopix_bit_timer #(
    .T0H_CYC(ns_to_cyc(SYSTEM_CLOCK, T0H_NS)),
    .T1H_CYC(ns_to_cyc(SYSTEM_CLOCK, T1H_NS)),
    .BIT_CYC(ns_to_cyc(SYSTEM_CLOCK, BIT_NS))
  ) u_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .i_start  (w_start),
    .i_run    (r_state == ST_SEND),
    .i_bit    (r_shift[23]),
    .i_last   (w_last),
    .o_done   (w_done),
    .o_first  (w_first),
    .o_do     (do_o)
  );
endmodule

// File: tb/tb_neopix_tx.sv
// tb_neopix_tx: directed/randomized frames checked cycle by cycle against an expected WS2812 waveform model.
module tb_neopix_tx;
  localparam int CYC  = 50_000_000 / 1_000_000;
  localparam int T0H  = CYC * 400 / 1000;
  localparam int T1H  = CYC * 800 / 1000;
  localparam int BITC = CYC * 1250 / 1000;
  localparam int LATC = CYC * 50;
  localparam int TMAX = 15000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic do_o;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  logic [23:0] mem [8];
  logic tr_do [TMAX];
  logic tr_busy [TMAX];
  logic tr_req [TMAX];
  logic [2:0] tr_addr [TMAX];
  neopix_if #(.NUM_LEDS(8)) bus ();
  neopix_tx #(.NUM_LEDS(8)) dut (.clk_i(clk), .reset_n_i(rst_n), .bus(bus.slave), .do_o(do_o));
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sample(input int t);
    @(negedge clk);
    tr_do[t]   = do_o;
    tr_busy[t] = bus.busy_o;
    tr_req[t]  = bus.data_request_o;
    tr_addr[t] = bus.address_o;
  endtask
  // RAM model: data for the requested address is valid the cycle after the request, garbage otherwise
  initial begin
    logic rq;
    logic [2:0] ra;
    {bus.green_i, bus.red_i, bus.blue_i} = 24'h0;
    forever begin
      @(negedge clk);
      rq = bus.data_request_o;
      ra = bus.address_o;
      @(posedge clk);
      #1;
      {bus.green_i, bus.red_i, bus.blue_i} = rq ? mem[ra] : 24'($urandom);
    end
  end
  task automatic run_frame(input int cnt, input int p1, input int p2, input bit pre, input int nxt);
    int n, bits, lat0, fall, cntv, nreq, last_req;
    n    = cnt > 8 ? 8 : cnt;
    bits = n * 24;
    lat0 = 4 + bits * BITC;
    fall = lat0 + LATC;
    if (!pre) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.led_count_i = 4'(cnt);
      sample(0);
    end else begin
      tr_do[0] = 1'b0; tr_busy[0] = 1'b0; tr_req[0] = 1'b0; tr_addr[0] = 3'd0;
    end
    for (int t = 1; t <= fall; t++) begin
      @(posedge clk);
      #1;
      if (t == 1 || t == p1 + 1 || t == p2 + 1) bus.start_i = 1'b0;
      if (t == p1 || t == p2) begin
        bus.start_i = 1'b1;
        bus.led_count_i = 4'($urandom_range(1, 15));
      end
      if (nxt > 0 && t == fall) begin
        bus.start_i = 1'b1;
        bus.led_count_i = 4'(nxt);
      end
      sample(t);
    end
    chk("busy_c1", 32'(tr_busy[1]), 1);
    chk("addr_c1", 32'(tr_addr[1]), 0);
    chk("req_c2", 32'(tr_req[2]), 1);
    chk("do_c3", 32'(tr_do[3]), 0);
    cntv = 0;
    for (int t = 1; t < fall; t++) cntv += tr_busy[t] ? 0 : 1;
    chk("busy_hold", 32'(cntv), 0);
    chk("busy_fall", 32'(tr_busy[fall]), 0);
    for (int b = 0; b < bits; b++) begin
      logic [23:0] w;
      int th, hi, bad, base;
      w    = mem[b / 24];
      th   = w[23 - (b % 24)] ? T1H : T0H;
      base = 4 + b * BITC;
      hi   = 0;
      bad  = 0;
      for (int o = 0; o < BITC; o++) begin
        hi  += tr_do[base + o] ? 1 : 0;
        bad += (tr_do[base + o] !== (o < th)) ? 1 : 0;
      end
      chk($sformatf("bit_hi[%0d]", b), 32'(hi), 32'(th));
      chk($sformatf("bit_wave[%0d]", b), 32'(bad), 0);
    end
    cntv = 0;
    for (int t = lat0; t <= fall; t++) cntv += tr_do[t] ? 1 : 0;
    chk("latch_low", 32'(cntv), 0);
    nreq = 0;
    last_req = 0;
    for (int t = 1; t <= fall; t++) if (tr_req[t]) begin
      if (nreq < n) begin
        chk($sformatf("req_addr[%0d]", nreq), 32'(tr_addr[t]), 32'(nreq));
        chk($sformatf("req_addr_pre[%0d]", nreq), 32'(tr_addr[t - 1]), 32'(nreq));
      end
      last_req = t;
      nreq++;
    end
    chk("req_count", 32'(nreq), 32'(n));
    chk("req_before_latch", 32'(last_req < lat0), 1);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.led_count_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_do", 32'(do_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_req", 32'(bus.data_request_o), 0);
    chk("rst_addr", 32'(bus.address_o), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    mem[0] = 24'h800001;
    run_frame(1, 0, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) mem[i] = 24'($urandom);
    run_frame(3, 500, 4 + 72 * BITC + 100, 1'b0, 0);
    begin
      int sb, sd, sr;
      sb = 0; sd = 0; sr = 0;
      @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.led_count_i = 4'd0;
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        sb += bus.busy_o ? 1 : 0;
        sd += do_o ? 1 : 0;
        sr += bus.data_request_o ? 1 : 0;
      end
      chk("zero_busy", 32'(sb), 0);
      chk("zero_do", 32'(sd), 0);
      chk("zero_req", 32'(sr), 0);
    end
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
    run_frame(15, 0, 0, 1'b0, 2);
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    run_frame(2, 0, 0, 1'b1, 0);
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.led_count_i = 4'd2;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (313) @(posedge clk);
    #3;
    chk("pre_rst_do", 32'(do_o), 1);
    chk("pre_rst_busy", 32'(bus.busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_do", 32'(do_o), 0);
    chk("async_rst_busy", 32'(bus.busy_o), 0);
    chk("async_rst_req", 32'(bus.data_request_o), 0);
    chk("async_rst_addr", 32'(bus.address_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    run_frame(2, 0, 0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
